// File: rtl/divider.sv
// divider: 32-bit unsigned restoring divider. One quotient bit is produced per
// clock under a three-state control FSM, and results are published through a
// start/ready handshake. A zero divisor completes immediately with an
// all-ones quotient and the dividend as remainder.
module divider (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Dividend_in,
  input  logic [31:0] Divisor_in,
  input  logic        start,
  output logic [31:0] Quotient_out,
  output logic [31:0] Remainder_out,
  output logic        ready,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [31:0] rem_reg;   // partial remainder
  logic [31:0] quo_reg;   // shifting dividend, becomes the quotient
  logic [31:0] dvs_reg;   // latched divisor
  logic [5:0]  cnt;       // iteration counter

  logic [32:0] shifted;
  logic [32:0] trial;
  logic [31:0] rem_step;
  logic [31:0] quo_step;
  logic        accept;
  logic        last_iter;

  // Start is honoured only when no division is running.
  assign accept    = start && (state != DIV);
  assign last_iter = (state == DIV) && (cnt == 6'd31);

  // One restoring iteration: shift in the next dividend bit, trial-subtract
  // the divisor, and keep the difference only when it did not go negative.
  always_comb begin
    // NOTE: every signal written here gets a value on every path, starting
    // with these defaults, so no latch can be inferred.
    shifted  = {rem_reg, quo_reg[31]};
    trial    = shifted - {1'b0, dvs_reg};
    rem_step = shifted[31:0];
    quo_step = {quo_reg[30:0], 1'b0};
    if (!trial[32]) begin
      rem_step = trial[31:0];
      quo_step = {quo_reg[30:0], 1'b1};
    end
  end

  // Control FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: non-blocking assignments for all clocked state, so every register
    // samples the pre-edge values regardless of block ordering.
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic: a zero divisor skips the loop and completes at once.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (start) state_nxt = (Divisor_in == 32'd0) ? DONE : DIV;
      end
      DIV: begin
        if (cnt == 6'd31) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath and result registers: load on accept, iterate in DIV, publish on
  // the last iteration or on a divide-by-zero accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem_reg       <= '0;
      quo_reg       <= '0;
      dvs_reg       <= '0;
      cnt           <= '0;
      Quotient_out  <= '0;
      Remainder_out <= '0;
      ready         <= 1'b0;
      div_by_zero   <= 1'b0;
    end else if (accept) begin
      rem_reg     <= '0;
      quo_reg     <= Dividend_in;
      dvs_reg     <= Divisor_in;
      cnt         <= '0;
      ready       <= 1'b0;
      div_by_zero <= 1'b0;
      if (Divisor_in == 32'd0) begin
        Quotient_out  <= 32'hFFFF_FFFF;
        Remainder_out <= Dividend_in;
        div_by_zero   <= 1'b1;
        ready         <= 1'b1;
      end
    end else if (state == DIV) begin
      rem_reg <= rem_step;
      quo_reg <= quo_step;
      cnt     <= cnt + 6'd1;
      if (last_iter) begin
        Quotient_out  <= quo_step;
        Remainder_out <= rem_step;
        ready         <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_divider.sv
// tb_divider: scoreboard bench for the divider. Expected results are pushed
// when a request is driven and popped when ready rises, along with the clock
// cycle on which the result is due.
module tb_divider;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Dividend_in;
  logic [31:0] Divisor_in;
  logic        start;
  logic [31:0] Quotient_out;
  logic [31:0] Remainder_out;
  logic        ready;
  logic        div_by_zero;

  typedef struct {
    logic [31:0] quo;
    logic [31:0] rem;
    logic        dbz;
    int          due;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  logic [31:0] last_quo = '0;
  logic [31:0] last_rem = '0;

  divider dut (
    .clk          (clk),
    .reset        (reset),
    .Dividend_in  (Dividend_in),
    .Divisor_in   (Divisor_in),
    .start        (start),
    .Quotient_out (Quotient_out),
    .Remainder_out(Remainder_out),
    .ready        (ready),
    .div_by_zero  (div_by_zero)
  );

  always #5 clk = ~clk;

  // Edge counter; at a falling edge it holds the index of the last rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Drive one request at the next rising edge; e0 is that accept edge.
  task automatic start_op(input logic [31:0] dvd, input logic [31:0] dvs,
                          input bit hold, output int e0);
    exp_t e;
    @(negedge clk);
    Dividend_in = dvd;
    Divisor_in  = dvs;
    start       = 1'b1;
    e0          = cyc + 1;
    if (dvs == 32'd0) begin
      e.quo = 32'hFFFF_FFFF;
      e.rem = dvd;
      e.dbz = 1'b1;
      e.due = e0;
    end else begin
      e.quo = dvd / dvs;
      e.rem = dvd % dvs;
      e.dbz = 1'b0;
      e.due = e0 + 32;
    end
    sb.push_back(e);
    @(negedge clk);
    if (!hold) start = 1'b0;
  endtask

  // Wait, bounded, until every expected result has been seen.
  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check({tag, "_timeout"}, sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Monitor: every rising edge of ready must match the oldest expectation.
  initial begin : monitor
    exp_t e;
    logic prev_ready;
    prev_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (ready && !prev_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_ready", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("quotient",    Quotient_out,  e.quo);
          check("remainder",   Remainder_out, e.rem);
          check("div_by_zero", div_by_zero,   e.dbz);
          check("ready_cycle", cyc,           e.due);
          last_quo = e.quo;
          last_rem = e.rem;
        end
      end
      prev_ready = ready;
    end
  end

  initial begin : stimulus
    int e0;
    reset       = 1'b1;
    start       = 1'b0;
    Dividend_in = '0;
    Divisor_in  = '0;
    repeat (2) @(negedge clk);
    check("rst_quotient",    Quotient_out,  32'd0);
    check("rst_remainder",   Remainder_out, 32'd0);
    check("rst_ready",       ready,         32'd0);
    check("rst_div_by_zero", div_by_zero,   32'd0);
    reset = 1'b0;

    // Basic divisions, including the extremes of the operand range.
    start_op(32'd100, 32'd7, 1'b0, e0);
    wait_idle("d100_7");
    start_op(32'hFFFF_FFFF, 32'd1, 1'b0, e0);
    wait_idle("dmax_1");
    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, e0);
    wait_idle("dmax_max");
    start_op(32'd5, 32'd10, 1'b0, e0);
    wait_idle("d5_10");

    // Divide by zero completes on the accept edge itself.
    pulse_reset();
    start_op(32'd123, 32'd0, 1'b0, e0);
    wait_idle("d123_0");

    // Start during DIV is ignored; previous results hold meanwhile.
    start_op(32'd1000, 32'd3, 1'b0, e0);
    check("accept_ready_low", ready,       32'd0);
    check("accept_dbz_clear", div_by_zero, 32'd0);
    repeat (9) @(negedge clk);
    check("hold_quotient",  Quotient_out,  last_quo);
    check("hold_remainder", Remainder_out, last_rem);
    Dividend_in = 32'd9;
    Divisor_in  = 32'd9;
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle("ignore_start");

    // Asynchronous reset mid-division aborts immediately.
    start_op(32'd1000, 32'd3, 1'b0, e0);
    repeat (15) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort_quotient",    Quotient_out,  32'd0);
    check("abort_remainder",   Remainder_out, 32'd0);
    check("abort_ready",       ready,         32'd0);
    check("abort_div_by_zero", div_by_zero,   32'd0);
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    start_op(32'd50, 32'd5, 1'b0, e0);
    wait_idle("d50_5");

    // Back-to-back with start held high: one-cycle ready pulse between results.
    start_op(32'd100, 32'd7, 1'b1, e0);
    Dividend_in = 32'd81;
    Divisor_in  = 32'd9;
    sb.push_back('{quo: 32'd9, rem: 32'd0, dbz: 1'b0, due: e0 + 65});
    repeat (33) @(negedge clk);
    check("b2b_ready_pulse", ready, 32'd0);
    start = 1'b0;
    wait_idle("b2b");

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/divider.md
# divider

Sequential 32-bit unsigned divider, the inverse datapath of the shift-add multiplier (Multiplicand / Product / Control). It holds the dividend and divisor in internal registers and runs a restoring shift-subtract loop, one quotient bit per clock, under a small control FSM. Results are published through a start/ready handshake. The block sits beside the multiplier as the CPU's divide unit.

## Interface

No parameters. Width is fixed at 32.

- clk  input  1  system clock; all state changes on the rising edge
- reset  input  1  asynchronous, active-high; clears all state and outputs immediately
- Dividend_in  input  32  unsigned dividend; sampled only on the edge that accepts start
- Divisor_in  input  32  unsigned divisor; sampled only on the edge that accepts start
- start  input  1  request a division; level-sampled on the rising edge
- Quotient_out  output  32  registered quotient of the last completed division
- Remainder_out  output  32  registered remainder of the last completed division
- ready  output  1  high when Quotient_out/Remainder_out hold a fresh result
- div_by_zero  output  1  high with ready when the last division had divisor 0

## Operation

- FSM states: IDLE, DIV, DONE. Reset state is IDLE.
- Internal registers:
  - R[31:0]: partial remainder
  - Q[31:0]: shifting dividend, then quotient
  - D[31:0]: latched divisor
  - cnt[5:0]: iteration counter
- IDLE or DONE with start=1:
  - Latch D=Divisor_in, Q=Dividend_in, R=0, cnt=0. Clear ready and div_by_zero.
  - If Divisor_in=0, go to DONE instead of DIV. Set Quotient_out=32'hFFFF_FFFF, Remainder_out=Dividend_in, div_by_zero=1, ready=1 on the same edge.
  - Otherwise go to DIV.
- DIV, each edge, one iteration:
  - Form the 33-bit value S={R,Q[31]}.
  - Compute T=S−{1'b0,D} at 33 bits.
  - If T is non-negative (T[32]=0): R=T[31:0] and Q={Q[30:0],1'b1}.
  - Otherwise: R=S[31:0] and Q={Q[30:0],1'b0}.
  - cnt increments.
  - On the iteration where cnt==31, compute the final R and Q as usual. On that same edge, set Quotient_out=final Q, Remainder_out=final R, ready=1, and go to DONE.
- DONE: outputs and ready hold until start=1 is sampled. Start is accepted exactly as in IDLE.
- start while in DIV is ignored. The running division is unaffected.
- Dividend_in and Divisor_in may change freely after the accept edge.
- Quotient_out and Remainder_out keep the previous result throughout DIV. They change only on the completion edge, the divide-by-zero accept edge, or reset.
- Invariant for divisor ≠ 0: Dividend = Quotient·Divisor + Remainder, with Remainder < Divisor.

## Timing

- Reset values: Quotient_out=0, Remainder_out=0, ready=0, div_by_zero=0, state=IDLE. All internal registers are 0.
- Reset asserted mid-DIV aborts at once. After reset is released, the block is in IDLE and needs a new start.
- Accept edge E0, where start is sampled in IDLE/DONE:
  - ready falls after E0.
  - Iterations occur on E1..E32.
  - ready rises after E32, so latency is 32 clocks after the accept edge.
- Divide by zero: ready and div_by_zero are high after E0 itself, a latency of 0 extra clocks.
- Back-to-back: start held high in DONE re-accepts on the next edge. ready is then high for exactly one cycle between divisions.
- Throughput: one division per 33 clocks.

## Test plan

- Reset, then Dividend=100, Divisor=7, start pulse at E0 -> ready=0 for E1..E31. After E32: Quotient=14, Remainder=2, ready=1, div_by_zero=0.
- 32'hFFFF_FFFF / 1 -> Quotient=32'hFFFF_FFFF, Remainder=0. Then 32'hFFFF_FFFF / 32'hFFFF_FFFF -> Quotient=1, Remainder=0. Then 5/10 -> Quotient=0, Remainder=5.
- Divisor=0, Dividend=123, start -> after E0: ready=1, div_by_zero=1, Quotient=32'hFFFF_FFFF, Remainder=123.
- Start 1000/3. At E10, drive start=1 with new operands 9/9 -> the new request is ignored. After E32: Quotient=333, Remainder=1.
- Start 1000/3. Assert reset asynchronously at E15+2ns -> all outputs 0 and ready=0 immediately. After release, 50/5 completes with Quotient=10, Remainder=0, 32 clocks after its accept edge.
- Hold start=1 continuously: 100/7 followed by 81/9 -> ready pulses for one cycle showing 14 r 2. The next ready shows 9 r 0, 33 clocks later.
